// File: rtl/lcd_fb_plotter.sv
// Pixel/fill command engine for the ST7920 12864 frame buffer.
// Does read-modify-write of single pixels or a full-buffer fill through the RAM write port.
module lcd_fb_plotter #(
    parameter int RD_LAT   = 1,
    parameter bit MSB_LEFT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [6:0] cmd_x,
    input  logic [5:0] cmd_y,
    input  logic [7:0] cmd_fill,
    output logic [9:0] fb_addr,
    input  logic [7:0] fb_rd_data,
    output logic       fb_wr_en,
    output logic [7:0] fb_wr_data,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_MOD, S_WR, S_FILL} state_t;

    localparam logic [1:0] OP_SET = 2'b00, OP_CLR = 2'b01, OP_TGL = 2'b10, OP_FILL = 2'b11;

    state_t     state, state_n;
    logic [1:0] op_q, op_n;
    logic [7:0] mask_q, mask_n;
    logic [1:0] cnt_q, cnt_n;
    logic [9:0] addr_n;
    logic [7:0] wdata_n;
    logic       wr_n, done_n, ready_n;
    logic [2:0] bit_idx;
    logic [7:0] new_byte;

    assign bit_idx = MSB_LEFT ? (3'd7 - cmd_x[2:0]) : cmd_x[2:0];

    always_comb begin
        case (op_q)
            OP_SET:  new_byte = fb_rd_data | mask_q;
            OP_CLR:  new_byte = fb_rd_data & ~mask_q;
            OP_TGL:  new_byte = fb_rd_data ^ mask_q;
            default: new_byte = fb_rd_data;
        endcase
    end

    always_comb begin
        state_n = state;
        op_n    = op_q;
        mask_n  = mask_q;
        cnt_n   = cnt_q;
        addr_n  = fb_addr;
        wdata_n = fb_wr_data;
        wr_n    = fb_wr_en;
        ready_n = cmd_ready;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    ready_n = 1'b0;
                    if (cmd_op == OP_FILL) begin
                        state_n = S_FILL;
                        addr_n  = 10'd0;
                        wdata_n = cmd_fill;
                        wr_n    = 1'b1;
                    end else begin
                        state_n = S_RD;
                        op_n    = cmd_op;
                        mask_n  = 8'b1 << bit_idx;
                        // rows 32..63 live in the right half (words 8..15) of rows 0..31
                        addr_n  = {cmd_y[4:0], cmd_y[5], cmd_x[6:3]};
                    end
                end
            end
            S_RD: begin
                if (RD_LAT > 1) begin
                    state_n = S_WAIT;
                    cnt_n   = 2'(RD_LAT - 2);
                end else begin
                    state_n = S_MOD;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) state_n = S_MOD;
                else               cnt_n   = cnt_q - 2'd1;
            end
            S_MOD: begin
                wdata_n = new_byte;
                wr_n    = 1'b1;
                state_n = S_WR;
            end
            S_WR: begin
                wr_n    = 1'b0;
                done_n  = 1'b1;
                ready_n = 1'b1;
                state_n = S_IDLE;
            end
            S_FILL: begin
                addr_n = fb_addr + 10'd1;
                if (fb_addr == 10'd1023) begin
                    wr_n    = 1'b0;
                    done_n  = 1'b1;
                    ready_n = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= 2'b00;
            mask_q     <= 8'h00;
            cnt_q      <= 2'd0;
            fb_addr    <= 10'd0;
            fb_wr_data <= 8'h00;
            fb_wr_en   <= 1'b0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            op_q       <= op_n;
            mask_q     <= mask_n;
            cnt_q      <= cnt_n;
            fb_addr    <= addr_n;
            fb_wr_data <= wdata_n;
            fb_wr_en   <= wr_n;
            cmd_ready  <= ready_n;
            busy       <= ~ready_n;
            done       <= done_n;
        end
    end
endmodule

// File: tb/tb_lcd_fb_plotter.sv
// Directed bench for lcd_fb_plotter: pixel RMW, fill, throughput and reset abort.
module tb_lcd_fb_plotter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_valid2;
    logic [1:0] cmd_op;
    logic [6:0] cmd_x;
    logic [5:0] cmd_y;
    logic [7:0] cmd_fill;
    logic       cmd_ready, busy, done, fb_wr_en;
    logic [9:0] fb_addr;
    logic [7:0] fb_wr_data, rd_q;
    logic       cmd_ready2, busy2, done2, fb_wr_en2;
    logic [9:0] fb_addr2;
    logic [7:0] fb_wr_data2;
    logic [7:0] mem [1024];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    lcd_fb_plotter #(.RD_LAT(1), .MSB_LEFT(1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_fill(cmd_fill),
        .fb_addr(fb_addr), .fb_rd_data(rd_q), .fb_wr_en(fb_wr_en),
        .fb_wr_data(fb_wr_data), .busy(busy), .done(done));

    // second build with two-cycle read latency, used only for throughput
    lcd_fb_plotter #(.RD_LAT(2), .MSB_LEFT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_fill(cmd_fill),
        .fb_addr(fb_addr2), .fb_rd_data(8'h00), .fb_wr_en(fb_wr_en2),
        .fb_wr_data(fb_wr_data2), .busy(busy2), .done(done2));

    // frame buffer model with one-cycle read latency
    always @(posedge clk) begin
        if (fb_wr_en) mem[fb_addr] <= fb_wr_data;
        rd_q <= mem[fb_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic px(input logic [1:0] op, input logic [6:0] x, input logic [5:0] y,
                      input logic [9:0] ea, input logic [7:0] ed, input string tag);
        int bad = 0;
        @(negedge clk);
        chk({tag, "_rdy"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({tag, "_busy"}, {busy, cmd_ready}, 2'b10);
        if (fb_wr_en || done) bad++;
        @(negedge clk);
        if (fb_wr_en || done || cmd_ready) bad++;
        @(negedge clk);
        chk({tag, "_wr"}, {fb_wr_en, done, cmd_ready, fb_addr, fb_wr_data}, {3'b100, ea, ed});
        @(negedge clk);
        chk({tag, "_done"}, {fb_wr_en, done, cmd_ready}, 3'b011);
        chk({tag, "_early"}, bad, 0);
    endtask

    task automatic fill(input logic [7:0] pat, input int abort_at, input string tag);
        int bad = 0;
        @(negedge clk);
        chk({tag, "_rdy"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_fill = pat; cmd_x = 7'd9; cmd_y = 6'd9;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            if (i > 0) @(negedge clk);
            if (!(fb_wr_en === 1'b1 && fb_addr === 10'(i) && fb_wr_data === pat &&
                  cmd_ready === 1'b0 && done === 1'b0)) bad++;
            if (i == abort_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk({tag, "_rst"}, {fb_wr_en, cmd_ready, done, fb_addr, fb_wr_data},
                    {3'b010, 10'd0, 8'h00});
                @(negedge clk);
                chk({tag, "_rst2"}, {fb_wr_en, cmd_ready, done}, 3'b010);
                chk({tag, "_seq"}, bad, 0);
                return;
            end
        end
        @(negedge clk);
        chk({tag, "_done"}, {fb_wr_en, done, cmd_ready}, 3'b011);
        chk({tag, "_seq"}, bad, 0);
    endtask

    initial begin
        int n1 = 0, n2 = 0;
        int hs1 [3];
        int hs2 [3];
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_valid2 = 1'b0;
        cmd_op = 2'b00; cmd_x = '0; cmd_y = '0; cmd_fill = '0;
        repeat (3) @(negedge clk);
        chk("reset", {cmd_ready, busy, fb_wr_en, done, fb_addr, fb_wr_data},
            {4'b1000, 10'd0, 8'h00});
        chk("reset2", {cmd_ready2, fb_wr_en2, done2}, 3'b100);
        rst_n = 1'b1;

        fill(8'h00, -1, "fill00");
        px(2'b00, 7'd0,   6'd0,  10'd0,    8'h80, "set_0_0");
        px(2'b00, 7'd127, 6'd63, 10'd1023, 8'h01, "set_127_63");
        px(2'b00, 7'd20,  6'd40, 10'd274,  8'h08, "set_20_40");

        fill(8'hAA, -1, "fillAA");
        fill(8'hFF, -1, "fillFF");
        px(2'b01, 7'd20, 6'd40, 10'd274, 8'hF7, "clr_20_40");
        px(2'b10, 7'd20, 6'd40, 10'd274, 8'hFF, "tgl_a");
        px(2'b10, 7'd20, 6'd40, 10'd274, 8'hF7, "tgl_b");
        chk("mem274", mem[274], 8'hF7);

        // back-to-back SETs with valid held high on both latency builds
        @(negedge clk);
        cmd_op = 2'b00; cmd_x = 7'd5; cmd_y = 6'd5;
        cmd_valid = 1'b1; cmd_valid2 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (n1 == 3) cmd_valid = 1'b0;
            if (n2 == 3) cmd_valid2 = 1'b0;
            if (cmd_valid && cmd_ready) begin hs1[n1] = c; n1++; end
            if (cmd_valid2 && cmd_ready2) begin hs2[n2] = c; n2++; end
        end
        chk("tp_n1", n1, 3);
        chk("tp_n2", n2, 3);
        if (n1 == 3) chk("tp_gap1", {hs1[1] - hs1[0], hs1[2] - hs1[1]}, {32'd4, 32'd4});
        if (n2 == 3) chk("tp_gap2", {hs2[1] - hs2[0], hs2[2] - hs2[1]}, {32'd5, 32'd5});

        fill(8'h55, 499, "fill_abort");
        chk("mem499", mem[499], 8'h55);
        px(2'b00, 7'd0, 6'd0, 10'd0, 8'hD5, "set_after_rst");
        px(2'b10, 7'd1, 6'd0, 10'd0, 8'h95, "tgl_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
